// File: rtl/multicycle_main_control_pkg.sv
// Shared encodings for the multicycle MIPS-32 main control FSM and its neighbours
// (the ALU control decoder imports the ALUOp constants from here).
package multicycle_main_control_pkg;

  localparam int OPW_DEFAULT = 6;
  localparam int SW_DEFAULT  = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB     = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Control-to-datapath bundle: opcode and memory handshake in, strobes and selects out.
interface multicycle_main_control_if #(
  parameter int OPW = 6,
  parameter int SW  = 4
);
  // Handshake: a memory access is requested by MemRead/MemWrite and completes in
  // the cycle mem_ready is high; the strobe stays asserted until that cycle.
  logic [OPW-1:0] opcode;
  logic           mem_ready;

  logic           PCWrite;
  logic           PCWriteCond;
  logic           IorD;
  logic           MemRead;
  logic           MemWrite;
  logic           IRWrite;
  logic           MemtoReg;
  logic           RegDst;
  logic           RegWrite;
  logic           ALUSrcA;
  logic [1:0]     ALUSrcB;
  logic [1:0]     ALUOp;
  logic [1:0]     PCSource;
  logic           illegal_op;
  logic [SW-1:0]  state;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           illegal_op, state
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multicycle MIPS-32 datapath: one state per clock,
// Moore outputs except the FETCH IR/PC loads, which wait for the memory.
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter int OPW = OPW_DEFAULT,
  parameter int SW  = SW_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_main_control_if.master bus
);

  state_t         state_q;
  logic           illegal_q;
  logic [OPW-1:0] op;
  ctrl_t          ctrl;
  ctrl_t          ctrl_o;

  assign op = bus.opcode;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_FETCH:     if (bus.mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_RTYPE:     state_q <= S_EXECUTE;
            OP_LW, OP_SW: state_q <= S_MEM_ADDR;
            OP_BEQ:       state_q <= S_BRANCH;
            OP_J:         state_q <= S_JUMP;
            OP_ADDI:      state_q <= S_ADDI_EXEC;
            default: begin
              state_q   <= S_FETCH;
              illegal_q <= 1'b1;
            end
          endcase
        end
        // IR is stable since FETCH, so this second opcode sample matches DECODE's.
        S_MEM_ADDR: begin
          if (op == OP_LW)      state_q <= S_MEM_READ;
          else if (op == OP_SW) state_q <= S_MEM_WRITE;
          else                  state_q <= S_FETCH;
        end
        S_MEM_READ:  if (bus.mem_ready) state_q <= S_MEM_WB;
        S_MEM_WRITE: if (bus.mem_ready) state_q <= S_FETCH;
        S_EXECUTE:   state_q <= S_R_WB;
        S_ADDI_EXEC: state_q <= S_ADDI_WB;
        S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                     state_q <= S_FETCH;
        default:     state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SHL2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REGB;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      default: ctrl = '0;
    endcase
  end

  // Reset kills every strobe in the same cycle, including a write already in flight.
  assign ctrl_o = reset ? '0 : ctrl;

  assign bus.PCWrite     = ctrl_o.pc_write;
  assign bus.PCWriteCond = ctrl_o.pc_write_cond;
  assign bus.IorD        = ctrl_o.iord;
  assign bus.MemRead     = ctrl_o.mem_read;
  assign bus.MemWrite    = ctrl_o.mem_write;
  assign bus.IRWrite     = ctrl_o.ir_write;
  assign bus.MemtoReg    = ctrl_o.mem_to_reg;
  assign bus.RegDst      = ctrl_o.reg_dst;
  assign bus.RegWrite    = ctrl_o.reg_write;
  assign bus.ALUSrcA     = ctrl_o.alu_src_a;
  assign bus.ALUSrcB     = ctrl_o.alu_src_b;
  assign bus.ALUOp       = ctrl_o.alu_op;
  assign bus.PCSource    = ctrl_o.pc_source;
  assign bus.illegal_op  = illegal_q & ~reset;
  assign bus.state       = reset ? '0 : SW'(state_q);

endmodule
